// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous memory between the CPU (port 0) and a
// loader/debug master (port 1). Each access is granted round-robin, driven to
// memory from registered address/data/write lines, and completed with a
// one-cycle ack pulse. The ack carries the read data on the shared rd_data bus.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   req0/1, wr0/1                  request and write flag per port
//   addr0/1, wr_data0/1            access address and write data per port
//   grant0/1                       port owns memory (access + capture states)
//   ack0/1                         one-cycle completion pulse
//   rd_data                        read data, valid while the owner's ack is high
//   busy                           arbiter is not idle
//   mem_addr, mem_wr_data, mem_wr  registered memory command
//   mem_rd_data                    memory read data, one cycle after mem_addr
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wr_data0,
    input  logic [DATA_WIDTH-1:0] wr_data1,
    output logic                  grant0,
    output logic                  grant1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [1:0]            req_vec;
    logic [1:0]            elig;
    logic [1:0]            ack_reg;
    logic [1:0]            grant_vec;
    logic                  last_reg;      // most recently served port
    logic                  op_wr_reg;     // owner's access is a write
    logic                  pick;          // port selected in S_IDLE
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wr_data_reg;
    logic                  mem_wr_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;

    assign req_vec = {req1, req0};

    // A port whose ack is high this cycle is masked, so the request it is
    // still holding (or has just replaced) is not taken for the old one.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = req_vec[gi] & ~ack_reg[gi];
        end
    endgenerate

    // Tie goes to the port that was not served last.
    assign pick = (elig == 2'b11) ? ~last_reg : elig[1];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (|elig) state_next = S_ACCESS;
            S_ACCESS:  state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Output logic: the owner is always last_reg while not idle.
    always_comb begin
        grant_vec = 2'b00;
        busy      = 1'b0;
        if (state_reg != S_IDLE) begin
            busy      = 1'b1;
            grant_vec = last_reg ? 2'b10 : 2'b01;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_reg        <= 1'b1;
            op_wr_reg       <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wr_data_reg <= '0;
            mem_wr_reg      <= 1'b0;
            rd_data_reg     <= '0;
            ack_reg         <= 2'b00;
        end else begin
            ack_reg <= 2'b00;
            case (state_reg)
                S_IDLE: begin
                    if (|elig) begin
                        last_reg        <= pick;
                        mem_addr_reg    <= pick ? addr1 : addr0;
                        mem_wr_data_reg <= pick ? wr_data1 : wr_data0;
                        mem_wr_reg      <= pick ? wr1 : wr0;
                        op_wr_reg       <= pick ? wr1 : wr0;
                    end
                end
                S_ACCESS: begin
                    mem_wr_reg <= 1'b0;
                end
                S_CAPTURE: begin
                    // Writes leave the previous read data on the bus.
                    if (!op_wr_reg) begin
                        rd_data_reg <= mem_rd_data;
                    end
                    ack_reg <= last_reg ? 2'b10 : 2'b01;
                end
                default: begin
                    mem_wr_reg <= 1'b0;
                end
            endcase
        end
    end

    assign grant0      = grant_vec[0];
    assign grant1      = grant_vec[1];
    assign ack0        = ack_reg[0];
    assign ack1        = ack_reg[1];
    assign rd_data     = rd_data_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wr_data = mem_wr_data_reg;
    assign mem_wr      = mem_wr_reg;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the CPU's single-port synchronous memory between the CPU (port 0) and a loader/debug master (port 1). Each access is granted round-robin, issued to memory from registered address/data/write lines, and completed with a one-cycle Ack pulse carrying read data. It sits between the CPU memory interface and the memory instance, replacing the direct CPU–memory connection.

## Interface
- AddrWidth, 8: memory address width.
- DataWidth, 16: memory word width.

- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req0 / Req1  in  1  access request, port 0 (CPU) / port 1 (loader).
- Wr0 / Wr1  in  1  1 = write, 0 = read; valid while Req high.
- Addr0 / Addr1  in  AddrWidth  access address.
- WrData0 / WrData1  in  DataWidth  write data.
- Grant0 / Grant1  out  1  port owns memory (S_Access and S_Capture).
- Ack0 / Ack1  out  1  one-cycle completion pulse.
- RdData  out  DataWidth  read data, valid while the owner's Ack is high; shared by both ports.
- Busy  out  1  state is not S_Idle.
- MemAddr  out  AddrWidth  address to memory (registered).
- MemWrData  out  DataWidth  write data to memory (registered).
- MemWr  out  1  memory write enable (registered).
- MemRdData  in  DataWidth  memory read data; valid the cycle after MemAddr is presented.

## Operation
- States: S_Idle → S_Access → S_Capture → S_Idle. There are no other states.
- S_Idle:
  - Eligible requester: Req high and its Ack not high in this cycle. The acked port's Req is masked for that one cycle.
  - No eligible requester: remain in S_Idle.
  - One eligible requester: select it.
  - Both eligible: select the port other than `last`, a 1-bit register holding the most recently served port.
  - On the edge: latch the owner's Addr/WrData/Wr into MemAddr/MemWrData/MemWr, set owner's Grant, set `last` = owner, go to S_Access.
- S_Access:
  - Memory samples MemAddr (and writes when MemWr = 1) at the end of this cycle.
  - On the edge: MemWr ← 0; go to S_Capture.
- S_Capture:
  - MemRdData is valid in this cycle.
  - On the edge: RdData ← MemRdData for reads (RdData holds its previous value for writes), owner's Ack ← 1, Grant ← 0, go to S_Idle.
- Ack is cleared on the following edge. Ack is never high for both ports at once.
- Requester rules:
  - Hold Req, Wr, Addr and WrData stable from assertion until Ack is seen.
  - In the Ack cycle, the requester may deassert Req or present the next request. The masked sample guarantees the old request is not re-issued.
- Req dropped before grant: no access occurs and no Ack is issued.
- Req dropped after grant: the access still completes and Ack still pulses.
- Reset values: Grant0 = Grant1 = Ack0 = Ack1 = Busy = MemWr = 0; MemAddr = MemWrData = RdData = 0; state = S_Idle; `last` = 1, so port 0 wins the first tie.
- Reset mid-operation: all registers clear immediately and asynchronously, including MemWr, so a write in S_Access may be lost. The pending Ack is never issued and the requester must re-issue.

## Timing
- Latency: Req sampled in S_Idle at cycle N → MemAddr/MemWr/Grant valid in cycle N+1 → MemRdData valid in N+2 → Ack and RdData valid in N+3.
- MemWr is high for exactly one cycle per write.
- Single requester, back to back: one access per 4 cycles (the Ack cycle is masked).
- Both ports continuously requesting: strict alternation 0,1,0,1…, one access per 3 cycles, so neither port can starve.
- Busy = 1 in S_Access and S_Capture.

## Test plan
- Reset held high with Req0 = Req1 = 1 → all outputs 0, Busy = 0; after Reset falls, the first grant goes to port 0.
- mem[0x05] = 0xBEEF; Req0 read 0x05 sampled at cycle 0 → MemAddr = 0x05 and Grant0 = 1 in cycle 1, Ack0 = 1 with RdData = 0xBEEF in cycle 3 only.
- Port 1 writes 0x1234 to 0x0A → MemWr = 1 in exactly one cycle; a subsequent port-0 read of 0x0A returns 0x1234.
- Req0 and Req1 asserted together and held, each presenting its next request on its Ack → grants in order 0,1,0,1, with Acks at cycles 3, 6, 9, 12.
- Port 0 alone, holding Req0 across Ack → second MemAddr appears in cycle 5 (4-cycle period); no duplicate access from the Ack cycle.
- Reset asserted in S_Access of a port-1 write → MemWr, Grant1 and Busy drop immediately; Ack1 never pulses; state returns to S_Idle.
